// File: rtl/noc_inject_arb.sv
// Packet-granular round-robin arbiter sharing one router injection channel among NREQ requesters.
// One cycle to arbitrate, registered flit outputs one cycle after acceptance; stalls on ordy of the locked VC.
module noc_inject_arb #(
    parameter int NREQ  = 4,
    parameter int DATAW = 63,
    parameter int VCH   = 1,
    parameter int VCHW  = 0
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic [NREQ*(DATAW+1)-1:0]    req_data,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_last,
    output logic [NREQ-1:0]              req_ready,
    input  logic [VCH:0]                 ordy,
    output logic [DATAW:0]               idata,
    output logic                         ivalid,
    output logic [VCHW:0]                ivch,
    output logic [NREQ-1:0]              owner
);
    localparam int PTRW = $clog2(NREQ);
    localparam int VW   = VCHW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]      state_q,   state_d;
    logic [PTRW-1:0] ptr_q,     ptr_d;
    logic [NREQ-1:0] owner_q,   owner_d;
    logic [VCHW:0]   vc_lock_q, vc_lock_d;
    logic [DATAW:0]  idata_q,   idata_d;
    logic            ivalid_q,  ivalid_d;
    logic [VCHW:0]   ivch_q,    ivch_d;

    logic [PTRW-1:0] hi_idx, lo_idx, win_idx, own_idx;
    logic            hi_fnd;
    logic [VCHW:0]   vc_sel;
    logic [DATAW:0]  sel_dat;
    logic            sel_last;
    logic            lock_rdy;
    logic            accept;

    // Rotating priority: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_fnd = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = PTRW'(i);
                if (PTRW'(i) >= ptr_q) begin
                    hi_idx = PTRW'(i);
                    hi_fnd = 1'b1;
                end
            end
        end
        win_idx = hi_fnd ? hi_idx : lo_idx;
    end

    always_comb begin
        vc_sel = '0;
        for (int v = VCH; v >= 0; v--) begin
            if (ordy[v]) begin
                vc_sel = VW'(v);
            end
        end
    end

    always_comb begin
        own_idx = '0;
        sel_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q[i]) begin
                own_idx = PTRW'(i);
                sel_dat = req_data[i*(DATAW+1) +: DATAW+1];
            end
        end
        sel_last = |(req_last & owner_q);
    end

    assign lock_rdy  = ordy[vc_lock_q];
    assign req_ready = (state_q == ST_BUSY && !rst_) ? (owner_q & req_valid & {NREQ{lock_rdy}}) : '0;
    assign accept    = |req_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        vc_lock_d = vc_lock_q;
        idata_d   = idata_q;
        ivalid_d  = 1'b0;
        ivch_d    = ivch_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid && |ordy) begin
                    owner_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    vc_lock_d = vc_sel;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    idata_d  = sel_dat;
                    ivalid_d = 1'b1;
                    ivch_d   = vc_lock_q;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                        ptr_d   = (own_idx == PTRW'(NREQ - 1)) ? '0 : own_idx + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            vc_lock_q <= '0;
            idata_q   <= '0;
            ivalid_q  <= 1'b0;
            ivch_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            vc_lock_q <= vc_lock_d;
            idata_q   <= idata_d;
            ivalid_q  <= ivalid_d;
            ivch_q    <= ivch_d;
        end
    end

    assign idata  = idata_q;
    assign ivalid = ivalid_q;
    assign ivch   = ivch_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_noc_inject_arb.sv
// Self-checking bench for noc_inject_arb: directed scenarios plus a randomized per-requester scoreboard.
module tb_noc_inject_arb;
    localparam int NREQ  = 4;
    localparam int DATAW = 63;
    localparam int VCH   = 1;
    localparam int VCHW  = 0;
    localparam int FW    = DATAW + 1;
    localparam int NPKT  = 1000;

    logic                  clk = 1'b0;
    logic                  rst_ = 1'b1;
    logic [NREQ*FW-1:0]    req_data = '0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic [VCH:0]          ordy = '0;
    logic [DATAW:0]        idata;
    logic                  ivalid;
    logic [VCHW:0]         ivch;
    logic [NREQ-1:0]       owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_inject_arb #(.NREQ(NREQ), .DATAW(DATAW), .VCH(VCH), .VCHW(VCHW)) dut (
        .clk(clk), .rst_(rst_), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .ordy(ordy), .idata(idata),
        .ivalid(ivalid), .ivch(ivch), .owner(owner)
    );

    function automatic logic [FW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [FW-1:0] mk_flit(int r, int p, int f, logic [31:0] s);
        logic [7:0]  rb = r[7:0];
        logic [15:0] pb = p[15:0];
        logic [7:0]  fb = f[7:0];
        return {rb, pb, fb, s};
    endfunction

    task automatic do_reset();
        rst_ = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        ordy = '0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        req_valid = '1;
        req_last = '1;
        ordy = '1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid got %b exp 0", ivalid); end
        checks++; if (idata !== '0) begin errors++; $display("FAIL reset_idata got %h exp 0", idata); end
        checks++; if (ivch !== '0) begin errors++; $display("FAIL reset_ivch got %h exp 0", ivch); end
        checks++; if (owner !== '0) begin errors++; $display("FAIL reset_owner got %b exp 0", owner); end
        checks++; if (dut.ptr_q !== '0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q); end
        do_reset();
    endtask

    task automatic test_reset_mid_packet();
        logic [FW-1:0] f [4];
        for (int i = 0; i < 4; i++) f[i] = rnd64();
        do_reset();
        ordy = 2'b11;
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_data[2*FW +: FW] = f[(c == 0) ? 0 : c - 1];
            #1;
            checks++;
            if (req_ready !== ((c == 0) ? 4'b0000 : 4'b0100)) begin
                errors++; $display("FAIL midrst_ready c%0d got %b", c, req_ready);
            end
        end
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || idata !== f[1]) begin errors++; $display("FAIL midrst_flit2 got %b %h exp 1 %h", ivalid, idata, f[1]); end
        req_data[2*FW +: FW] = f[2];
        rst_ = 1'b1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL midrst_ready_in_rst got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL midrst_ivalid got %b exp 0", ivalid); end
        checks++; if (owner !== '0) begin errors++; $display("FAIL midrst_owner got %b exp 0", owner); end
        checks++; if (dut.ptr_q !== '0) begin errors++; $display("FAIL midrst_ptr got %0d exp 0", dut.ptr_q); end
        rst_ = 1'b0;
        req_valid = '1;
        req_last = '1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL midrst_arb_ready got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (owner !== 4'b0001) begin errors++; $display("FAIL midrst_winner got %b exp 0001", owner); end
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_win_ready got %b exp 0001", req_ready); end
    endtask

    // Each 2-flit packet occupies exactly 3 cycles: arbitration, flit 0, flit 1.
    task automatic test_rr_fairness();
        int fidx [NREQ];
        int phase, pkt, pr, pf;
        logic [NREQ-1:0] exp_own;
        logic [FW-1:0] exp_dat;
        do_reset();
        for (int r = 0; r < NREQ; r++) fidx[r] = 0;
        ordy = 2'b11;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            phase = c % 3;
            pkt = c / 3;
            exp_own = (phase == 0) ? '0 : (NREQ'(1) << (pkt % NREQ));
            checks++; if (owner !== exp_own) begin errors++; $display("FAIL rr_owner c%0d got %b exp %b", c, owner, exp_own); end
            if (c > 0 && phase != 1) begin
                pr = (phase == 2) ? pkt % NREQ : (pkt - 1) % NREQ;
                pf = (phase == 2) ? 0 : 1;
                exp_dat = FW'(64'hA500 + pr * 256 + pf);
                checks++;
                if (ivalid !== 1'b1 || idata !== exp_dat || ivch !== '0) begin
                    errors++; $display("FAIL rr_flit c%0d got %b %h vc%0d exp 1 %h vc0", c, ivalid, idata, ivch, exp_dat);
                end
            end else begin
                checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL rr_idle c%0d got %b exp 0", c, ivalid); end
            end
            req_valid = '1;
            for (int r = 0; r < NREQ; r++) begin
                req_last[r] = (fidx[r] == 1);
                req_data[r*FW +: FW] = FW'(64'hA500 + r * 256 + fidx[r]);
            end
            #1;
            checks++; if (req_ready !== exp_own) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, req_ready, exp_own); end
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) fidx[r] = (fidx[r] == 1) ? 0 : 1;
        end
    endtask

    task automatic test_vc_lock();
        logic [FW-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = rnd64();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_last = '0; ordy = 2'b10; req_data[FW +: FW] = d[0];
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL vc_arb_ready got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (owner !== 4'b0010) begin errors++; $display("FAIL vc_owner got %b exp 0010", owner); end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL vc_f1_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || ivch !== 1'b1 || idata !== d[0]) begin errors++; $display("FAIL vc_f1_out got %b vc%0d %h exp 1 vc1 %h", ivalid, ivch, idata, d[0]); end
        req_data[FW +: FW] = d[1]; ordy = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL vc_stall_ready c%0d got %b exp 0", c, req_ready); end
            @(negedge clk);
            checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL vc_stall_ivalid c%0d got %b exp 0", c, ivalid); end
        end
        ordy = 2'b11;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL vc_f2_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || ivch !== 1'b1 || idata !== d[1]) begin errors++; $display("FAIL vc_f2_out got %b vc%0d %h exp 1 vc1 %h", ivalid, ivch, idata, d[1]); end
        req_data[FW +: FW] = d[2]; req_last = 4'b0010; ordy = 2'b10;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL vc_f3_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (ivalid !== 1'b1 || ivch !== 1'b1 || idata !== d[2]) begin errors++; $display("FAIL vc_f3_out got %b vc%0d %h exp 1 vc1 %h", ivalid, ivch, idata, d[2]); end
        checks++; if (owner !== '0) begin errors++; $display("FAIL vc_release got %b exp 0", owner); end
    endtask

    task automatic test_owner_bubble();
        logic [FW-1:0] f [4];
        for (int i = 0; i < 4; i++) f[i] = rnd64();
        do_reset();
        @(negedge clk);
        ordy = 2'b11; req_valid = 4'b1001; req_last = '0;
        req_data[0 +: FW] = f[0]; req_data[3*FW +: FW] = rnd64();
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL bub_arb_ready got %b exp 0", req_ready); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_data[0 +: FW] = f[c];
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bub_head_ready c%0d got %b exp 0001", c, req_ready); end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (c == 0) begin
                if (ivalid !== 1'b1 || idata !== f[1]) begin errors++; $display("FAIL bub_f1_out got %b %h exp 1 %h", ivalid, idata, f[1]); end
            end else if (ivalid !== 1'b0) begin
                errors++; $display("FAIL bub_gap_ivalid c%0d got %b exp 0", c, ivalid);
            end
            req_valid = 4'b1000; req_data[0 +: FW] = f[2];
            #1;
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bub_gap_ready c%0d got %b exp 0", c, req_ready); end
        end
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL bub_gap_ivalid c2 got %b exp 0", ivalid); end
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bub_f2_ready got %b exp 0001", req_ready); end
        @(negedge clk);
        req_data[0 +: FW] = f[3]; req_last = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bub_f3_ready got %b exp 0001", req_ready); end
        checks++; if (ivalid !== 1'b1 || idata !== f[2] || ivch !== '0) begin errors++; $display("FAIL bub_f2_out got %b %h vc%0d exp 1 %h vc0", ivalid, idata, ivch, f[2]); end
        @(negedge clk);
        req_valid = 4'b1000; req_last = '0;
        checks++; if (ivalid !== 1'b1 || idata !== f[3] || ivch !== '0) begin errors++; $display("FAIL bub_f3_out got %b %h vc%0d exp 1 %h vc0", ivalid, idata, ivch, f[3]); end
        @(negedge clk);
        checks++; if (owner !== 4'b1000) begin errors++; $display("FAIL bub_next_owner got %b exp 1000", owner); end
    endtask

    task automatic test_single_flit();
        logic [FW-1:0] d0, d1;
        d0 = rnd64(); d1 = rnd64();
        do_reset();
        @(negedge clk);
        ordy = 2'b11; req_valid = 4'b0011; req_last = 4'b0011;
        req_data[0 +: FW] = d0; req_data[FW +: FW] = d1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL sf_arb0 got %b exp 0", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sf_flit0 got %b exp 0001", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || idata !== d0) begin errors++; $display("FAIL sf_out0 got %b %h exp 1 %h", ivalid, idata, d0); end
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL sf_arb1 got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL sf_gap got %b exp 0", ivalid); end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sf_flit1 got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = '0; req_last = '0;
        checks++; if (ivalid !== 1'b1 || idata !== d1 || owner !== '0) begin errors++; $display("FAIL sf_out1 got %b %h own %b exp 1 %h own 0", ivalid, idata, owner, d1); end
    endtask

    // Scoreboard: each requester emits a known flit sequence; the router side must see
    // each packet whole, in order, on one VC that was ready when each flit was accepted.
    task automatic test_random();
        int pkt_cnt [NREQ];
        int plen [NREQ];
        int fidx [NREQ];
        logic [31:0] salt [NREQ];
        int cur_own, done_pkts, cyc, ar;
        bit prev_tail, pend_vld, pend_first;
        logic [FW-1:0] pend_dat;
        logic [VCH:0] pend_ordy;
        logic [VCHW:0] pkt_vc;
        logic [NREQ-1:0] acc;
        cur_own = -1; done_pkts = 0; cyc = 0; ar = 0;
        prev_tail = 0; pend_vld = 0; pend_first = 0;
        pend_dat = '0; pend_ordy = '0; pkt_vc = '0;
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            pkt_cnt[r] = 0; fidx[r] = 0;
            plen[r] = $urandom_range(1, 8);
            salt[r] = $urandom;
        end
        while ((done_pkts < NPKT || pend_vld) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (pend_vld) begin
                checks++; if (ivalid !== 1'b1 || idata !== pend_dat) begin errors++; $display("FAIL rnd_flit cyc%0d got %b %h exp 1 %h", cyc, ivalid, idata, pend_dat); end
                if (pend_first) pkt_vc = ivch;
                else begin
                    checks++; if (ivch !== pkt_vc) begin errors++; $display("FAIL rnd_vc_const cyc%0d got %0d exp %0d", cyc, ivch, pkt_vc); end
                end
                checks++; if (pend_ordy[ivch] !== 1'b1) begin errors++; $display("FAIL rnd_ordy cyc%0d vc%0d ordy %b exp ready", cyc, ivch, pend_ordy); end
            end else begin
                checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL rnd_idle cyc%0d got %b exp 0", cyc, ivalid); end
            end
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r] = (pkt_cnt[r] < NPKT / NREQ) && ($urandom_range(0, 3) != 0);
                req_last[r] = (fidx[r] == plen[r] - 1);
                req_data[r*FW +: FW] = mk_flit(r, pkt_cnt[r], fidx[r], salt[r]);
            end
            ordy[0] = ($urandom_range(0, 3) != 0);
            ordy[1] = ($urandom_range(0, 3) != 0);
            #1;
            acc = req_ready;
            checks++; if ($countones(acc) > 1 || (acc & ~req_valid) != '0) begin errors++; $display("FAIL rnd_ready_shape cyc%0d got %b valid %b", cyc, acc, req_valid); end
            if (prev_tail) begin
                checks++; if (acc !== '0) begin errors++; $display("FAIL rnd_arb_gap cyc%0d got %b exp 0", cyc, acc); end
            end
            pend_vld = 0; prev_tail = 0;
            if (acc != '0) begin
                for (int r = 0; r < NREQ; r++) if (acc[r]) ar = r;
                checks++; if (cur_own != -1 && cur_own != ar) begin errors++; $display("FAIL rnd_interleave cyc%0d got req%0d exp req%0d", cyc, ar, cur_own); end
                pend_vld = 1;
                pend_first = (fidx[ar] == 0);
                pend_dat = mk_flit(ar, pkt_cnt[ar], fidx[ar], salt[ar]);
                pend_ordy = ordy;
                if (fidx[ar] == plen[ar] - 1) begin
                    pkt_cnt[ar]++; done_pkts++;
                    fidx[ar] = 0;
                    plen[ar] = $urandom_range(1, 8);
                    salt[ar] = $urandom;
                    cur_own = -1; prev_tail = 1;
                end else begin
                    fidx[ar]++;
                    cur_own = ar;
                end
            end
        end
        req_valid = '0;
        checks++; if (done_pkts != NPKT) begin errors++; $display("FAIL rnd_timeout got %0d packets exp %0d", done_pkts, NPKT); end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_vc_lock();
        test_owner_bubble();
        test_single_flit();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
